// File: rtl/store_rmw_unit.sv
// Read-modify-write sequencer for sw/sh/sb in the multicycle datapath.
// Sub-word stores read the target word into mdr_q for the external merge stage; word stores write directly.
module store_rmw_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr_q,
  output logic [1:0]        ssize_ctrl,
  input  logic [DATA_W-1:0] merged_in
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic              accept;
  logic              sub_word;

  assign accept   = (state_q == S_IDLE) && start;
  assign sub_word = (size == 2'b01) || (size == 2'b10);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: mdr_q is a single register, not a RAM, so it takes the async reset
  // like everything else; it is deliberately not cleared on word stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      lat_cnt <= '0;
      mdr_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        size_q  <= size;
        lat_cnt <= '0;
      end else if ((state_q == S_READ) && (lat_cnt != LAT_LAST)) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (state_q == S_CAPTURE) begin
        mdr_q <= mem_rdata;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = sub_word ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        mem_rd = 1'b1;
        if (lat_cnt == LAT_LAST) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        mem_rd  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_wr  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = merged_in;
  // Size code 11 is a word store; the merge stage only ever sees 00/01/10.
  assign ssize_ctrl = (size_q == 2'b11) ? 2'b00 : size_q;

  a_strobes_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(mem_rd && mem_wr));
  a_done_single_cycle : assert property (@(posedge clk) disable iff (reset)
    done |=> !done);

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each with its own word memory model and a bench-side merge stage.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_b = 32'h0;

  logic        start     [2];
  logic        busy      [2];
  logic        done      [2];
  logic [31:0] mem_addr  [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mdr_q     [2];
  logic [1:0]  ssize_ctrl[2];
  logic [31:0] merged_in [2];

  logic [31:0] mem [2][1024];
  int          rd_cnt [2];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .start(start[0]), .size(size), .addr(addr),
    .busy(busy[0]), .done(done[0]), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
    .mem_wr(mem_wr[0]), .mem_rdata(mem_rdata[0]), .mem_wdata(mem_wdata[0]),
    .mdr_q(mdr_q[0]), .ssize_ctrl(ssize_ctrl[0]), .merged_in(merged_in[0])
  );

  store_rmw_unit #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset), .start(start[1]), .size(size), .addr(addr),
    .busy(busy[1]), .done(done[1]), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
    .mem_wr(mem_wr[1]), .mem_rdata(mem_rdata[1]), .mem_wdata(mem_wdata[1]),
    .mdr_q(mdr_q[1]), .ssize_ctrl(ssize_ctrl[1]), .merged_in(merged_in[1])
  );

  // Read data is garbage until the read strobe has been held for MEM_LAT cycles.
  assign mem_rdata[0] = (mem_rd[0] && rd_cnt[0] >= 1) ? mem[0][mem_addr[0][11:2]] : 32'hDEADBEEF;
  assign mem_rdata[1] = (mem_rd[1] && rd_cnt[1] >= 3) ? mem[1][mem_addr[1][11:2]] : 32'hDEADBEEF;

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] ctl,
                                        input logic [31:0] b, input logic [1:0] lo);
    logic [31:0] r;
    r = w;
    case (ctl)
      2'b00: r = b;
      2'b01: if (lo[1]) r[31:16] = b[15:0]; else r[15:0] = b[15:0];
      2'b10: case (lo)
               2'd0: r[7:0]   = b[7:0];
               2'd1: r[15:8]  = b[7:0];
               2'd2: r[23:16] = b[7:0];
               default: r[31:24] = b[7:0];
             endcase
      default: r = 32'hBAD0BAD0;
    endcase
    return r;
  endfunction

  assign merged_in[0] = merge(mdr_q[0], ssize_ctrl[0], store_b, mem_addr[0][1:0]);
  assign merged_in[1] = merge(mdr_q[1], ssize_ctrl[1], store_b, mem_addr[1][1:0]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int          n_rd, first_rd, n_wr, n_done, both;
  int          wr_cyc [4];
  logic [31:0] wr_adr [4];
  logic [31:0] wr_dat [4];
  int          done_cyc [4];

  // Runs one store on instance s and records strobes for 14 cycles after the start edge.
  // p_busy / p_after: cycles at which start is re-pulsed with addr 0x200, word size.
  // rc: cycle at which reset is asserted mid-clock.
  task automatic op(input int s, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] init,
                    input int p_busy, input int p_after, input int rc);
    logic        rd_now, wr_now;
    logic [31:0] wa, wd;
    @(negedge clk);
    mem[s][10'h40] = init;
    store_b   = b;
    rd_cnt[s] = 0;
    n_rd = 0; first_rd = 0; n_wr = 0; n_done = 0; both = 0;
    for (int i = 0; i < 4; i++) begin
      wr_cyc[i] = -1; wr_adr[i] = '0; wr_dat[i] = '0; done_cyc[i] = -1;
    end
    size = sz; addr = a; start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0; addr = 32'h3FC; size = 2'b00;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      rd_now = mem_rd[s]; wr_now = mem_wr[s]; wa = mem_addr[s]; wd = mem_wdata[s];
      if (rd_now) begin
        if (n_rd == 0) first_rd = cyc;
        n_rd++;
      end
      if (rd_now && wr_now) both++;
      if (wr_now) begin
        if (n_wr < 4) begin
          wr_cyc[n_wr] = cyc; wr_adr[n_wr] = wa; wr_dat[n_wr] = wd;
        end
        n_wr++;
      end
      if (done[s]) begin
        if (n_done < 4) done_cyc[n_done] = cyc;
        n_done++;
      end
      if (cyc == p_busy || cyc == p_after) begin
        start[s] = 1'b1; addr = 32'h200; size = 2'b00;
      end
      if (cyc == rc) begin
        reset = 1'b1;
        #1;
        check("midop_reset_ctl", 32'({busy[s], done[s], mem_rd[s], mem_wr[s], ssize_ctrl[s]}), 32'h0);
        check("midop_reset_addr", mem_addr[s], 32'h0);
        check("midop_reset_mdr", mdr_q[s], 32'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0; start[s] = 1'b0; addr = 32'h3FC; size = 2'b00;
      if (wr_now) mem[s][wa[11:2]] = wd;
      rd_cnt[s] = rd_now ? rd_cnt[s] + 1 : 0;
    end
  endtask

  typedef struct {
    int          s;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] init;
    int          e_nrd;
    int          e_first;
    int          e_wcyc;
    logic [31:0] e_wdata;
    int          e_done;
    logic [31:0] e_mdr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    start[0] = 1'b0;
    start[1] = 1'b0;
    rd_cnt[0] = 0;
    rd_cnt[1] = 0;

    // Power-on reset asserted mid-clock; outputs must clear without an edge.
    #3 reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("por_ctl", 32'({busy[s], done[s], mem_rd[s], mem_wr[s], ssize_ctrl[s]}), 32'h0);
      check("por_addr", mem_addr[s], 32'h0);
      check("por_mdr", mdr_q[s], 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    //            s  size   addr        B             init          nrd first wcyc wdata         done mdr
    vecs[0] = '{0, 2'b10, 32'h100, 32'h11223344, 32'hAABBCCDD, 2, 1, 3, 32'hAABBCC44, 4, 32'hAABBCCDD};
    vecs[1] = '{0, 2'b01, 32'h100, 32'h11223344, 32'hAABBCCDD, 2, 1, 3, 32'hAABB3344, 4, 32'hAABBCCDD};
    vecs[2] = '{0, 2'b00, 32'h100, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'h11223344, 2, 32'hAABBCCDD};
    vecs[3] = '{0, 2'b11, 32'h100, 32'h11223344, 32'hAABBCCDD, 0, 0, 1, 32'h11223344, 2, 32'hAABBCCDD};
    vecs[4] = '{1, 2'b10, 32'h101, 32'h11223344, 32'hAABBCCDD, 4, 1, 5, 32'hAABB44DD, 6, 32'hAABBCCDD};
    vecs[5] = '{1, 2'b01, 32'h102, 32'h11223344, 32'hAABBCCDD, 4, 1, 5, 32'h3344CCDD, 6, 32'hAABBCCDD};
    vecs[6] = '{0, 2'b10, 32'h103, 32'h11223344, 32'hAABBCCDD, 2, 1, 3, 32'h44BBCCDD, 4, 32'hAABBCCDD};

    for (int v = 0; v < 7; v++) begin
      op(vecs[v].s, vecs[v].sz, vecs[v].a, vecs[v].b, vecs[v].init, -1, -1, -1);
      check($sformatf("v%0d_n_rd", v), n_rd, vecs[v].e_nrd);
      check($sformatf("v%0d_first_rd", v), first_rd, vecs[v].e_first);
      check($sformatf("v%0d_n_wr", v), n_wr, 1);
      check($sformatf("v%0d_wr_cycle", v), wr_cyc[0], vecs[v].e_wcyc);
      check($sformatf("v%0d_wr_addr", v), wr_adr[0], vecs[v].a);
      check($sformatf("v%0d_wr_data", v), wr_dat[0], vecs[v].e_wdata);
      check($sformatf("v%0d_n_done", v), n_done, 1);
      check($sformatf("v%0d_done_cycle", v), done_cyc[0], vecs[v].e_done);
      check($sformatf("v%0d_strobe_overlap", v), both, 0);
      check($sformatf("v%0d_mdr", v), mdr_q[vecs[v].s], vecs[v].e_mdr);
      check($sformatf("v%0d_mem", v), mem[vecs[v].s][10'h40], vecs[v].e_wdata);
    end

    // MEM_LAT=3 byte store, start re-pulsed to 0x200 while busy (ignored),
    // then again in the cycle after DONE (accepted as a word store).
    mem[1][10'h80] = 32'h55555555;
    op(1, 2'b10, 32'h100, 32'h11223344, 32'hAABBCCDD, 2, 7, -1);
    check("b2b_n_rd", n_rd, 4);
    check("b2b_n_wr", n_wr, 2);
    check("b2b_wr0_cycle", wr_cyc[0], 5);
    check("b2b_wr0_addr", wr_adr[0], 32'h100);
    check("b2b_wr0_data", wr_dat[0], 32'hAABBCC44);
    check("b2b_done0", done_cyc[0], 6);
    check("b2b_wr1_cycle", wr_cyc[1], 8);
    check("b2b_wr1_addr", wr_adr[1], 32'h200);
    check("b2b_wr1_data", wr_dat[1], 32'h11223344);
    check("b2b_done1", done_cyc[1], 9);
    check("b2b_n_done", n_done, 2);
    check("b2b_mem100", mem[1][10'h40], 32'hAABBCC44);

    // Reset during READ: the pending write must never be issued.
    op(1, 2'b10, 32'h100, 32'h11223344, 32'hAABBCCDD, -1, -1, 2);
    check("rst_read_n_wr", n_wr, 0);
    check("rst_read_n_done", n_done, 0);
    check("rst_read_mem", mem[1][10'h40], 32'hAABBCCDD);

    // The next byte store after the aborted one completes normally.
    op(1, 2'b10, 32'h100, 32'h11223344, 32'hAABBCCDD, -1, -1, -1);
    check("post_rst_n_wr", n_wr, 1);
    check("post_rst_wr_cycle", wr_cyc[0], 5);
    check("post_rst_wr_data", wr_dat[0], 32'hAABBCC44);
    check("post_rst_done", done_cyc[0], 6);
    check("post_rst_mdr", mdr_q[1], 32'hAABBCCDD);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
